// File: rtl/comp_sched.sv
// Shares one comparator between NCH channels: round-robin grant, clear, settle, majority-vote sampling.
// Latency: request sampled in IDLE -> VDONE pulse after 2+SETTLE+SAMPLES cycles; back-to-back spacing 3+SETTLE+SAMPLES.
// Backpressure: none; VREQ is level-held and only sampled in IDLE, so later requests simply wait their turn.
module comp_sched #(
  parameter  int NCH     = 4,
  parameter  int SETTLE  = 3,
  parameter  int SAMPLES = 3,
  localparam int SELW    = $clog2(NCH)
) (
  input  logic            CLK,
  input  logic            VRESET_N,
  input  logic [NCH-1:0]  VREQ,
  input  logic            VCOMP,
  output logic [SELW-1:0] VSEL,
  output logic            VCLR,
  output logic            VENABLE,
  output logic            VBUSY,
  output logic [NCH-1:0]  VDONE,
  output logic [NCH-1:0]  VRESULT
);

  // Ones-count sized to hold SAMPLES without wrapping; cycle counter covers 1..15.
  localparam int              OW          = $clog2(SAMPLES + 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]      SAMPLE_LAST = 4'(SAMPLES - 1);
  localparam logic [OW-1:0]   HALF        = OW'(SAMPLES / 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SELW-1:0] ptr;
  logic [3:0]      cnt;
  logic [OW-1:0]   ones;
  logic [OW-1:0]   ones_inc;
  logic [SELW-1:0] grant_idx;
  logic [SELW-1:0] cand;
  logic            found;

  assign ones_inc = ones + OW'(VCOMP);

  // Round-robin search: first requester strictly after the last-granted pointer, wrapping.
  always_comb begin
    grant_idx = ptr;
    cand      = ptr;
    found     = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      cand = SELW'((int'(ptr) + i) % NCH);
      if (!found && VREQ[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  // Next-state decode; SETTLE and SAMPLE lengths are timed by the shared cycle counter.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|VREQ) state_nxt = ST_CLEAR;
      ST_CLEAR:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (cnt == SAMPLE_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset returns to IDLE immediately, aborting any conversion.
  always_ff @(posedge CLK or negedge VRESET_N) begin
    if (!VRESET_N) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Grant capture, counters, result write on the last sample edge, pointer update on DONE exit.
  always_ff @(posedge CLK or negedge VRESET_N) begin
    if (!VRESET_N) begin
      VSEL    <= '0;
      ptr     <= SELW'(NCH - 1);
      cnt     <= '0;
      ones    <= '0;
      VRESULT <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|VREQ) VSEL <= grant_idx;
          cnt  <= '0;
          ones <= '0;
        end
        ST_CLEAR: begin
          cnt  <= '0;
          ones <= '0;
        end
        ST_SETTLE: begin
          cnt <= (cnt == SETTLE_LAST) ? 4'd0 : cnt + 4'd1;
        end
        ST_SAMPLE: begin
          ones <= ones_inc;
          cnt  <= cnt + 4'd1;
          if (cnt == SAMPLE_LAST) VRESULT[VSEL] <= (ones_inc > HALF);
        end
        ST_DONE: begin
          ptr <= VSEL;
          cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs decoded purely from registered state and the held grant.
  always_comb begin
    VCLR    = (state == ST_CLEAR);
    VENABLE = (state == ST_SAMPLE);
    VBUSY   = (state != ST_IDLE);
    VDONE   = '0;
    if (state == ST_DONE) VDONE[VSEL] = 1'b1;
  end

endmodule

// File: tb/tb_comp_sched.sv
// Directed bench for comp_sched at default parameters (NCH=4, SETTLE=3, SAMPLES=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_comp_sched;

  logic       CLK = 1'b0;
  logic       VRESET_N;
  logic [3:0] VREQ;
  logic       VCOMP;
  logic [1:0] VSEL;
  logic       VCLR;
  logic       VENABLE;
  logic       VBUSY;
  logic [3:0] VDONE;
  logic [3:0] VRESULT;

  int n_tests = 0;
  int n_fail  = 0;

  comp_sched #(.NCH(4), .SETTLE(3), .SAMPLES(3)) dut (
    .CLK     (CLK),
    .VRESET_N(VRESET_N),
    .VREQ    (VREQ),
    .VCOMP   (VCOMP),
    .VSEL    (VSEL),
    .VCLR    (VCLR),
    .VENABLE (VENABLE),
    .VBUSY   (VBUSY),
    .VDONE   (VDONE),
    .VRESULT (VRESULT)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion starting at a falling edge while the DUT is idle.
  // spat drives VCOMP before/through SETTLE, pat drives VCOMP over the sample window (bit 0 first).
  task automatic conv(input logic [3:0] req, input logic [2:0] spat, input logic [2:0] pat,
                      input int drop_at, input logic [1:0] sel, input logic [3:0] exp_res,
                      input string tag);
    int ena;
    int clr;
    logic [3:0] exp_done;
    ena = 0;
    clr = 0;
    exp_done = 4'b0001 << sel;
    VREQ  = req;
    VCOMP = spat[0];
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      ena += int'(VENABLE);
      clr += int'(VCLR);
      if (c == 1) begin
        chk({tag, ".clr_first"}, VCLR, 1'b1);
        chk({tag, ".sel"}, VSEL, sel);
        chk({tag, ".busy"}, VBUSY, 1'b1);
      end
      if (c == 7) chk({tag, ".no_early_done"}, VDONE, 4'b0000);
      if (c == 8) begin
        chk({tag, ".done"}, VDONE, exp_done);
        chk({tag, ".result"}, VRESULT, exp_res);
        chk({tag, ".ena_off_in_done"}, VENABLE, 1'b0);
      end
      if (c == drop_at) VREQ = 4'b0000;
      if (c >= 2 && c <= 4) VCOMP = spat[c-2];
      if (c >= 5 && c <= 7) VCOMP = pat[c-5];
    end
    chk({tag, ".ena_cycles"}, ena, 3);
    chk({tag, ".clr_cycles"}, clr, 1);
    VREQ  = 4'b0000;
    VCOMP = 1'b0;
    cyc(1);
    chk({tag, ".done_one_cycle"}, VDONE, 4'b0000);
    chk({tag, ".idle"}, VBUSY, 1'b0);
    chk({tag, ".sel_hold"}, VSEL, sel);
  endtask

  logic [3:0] rr_exp [5];
  int t;
  int np;
  int last;

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    VRESET_N = 1'b0;
    VREQ     = 4'b0000;
    VCOMP    = 1'b0;
    cyc(2);
    chk("rst.sel", VSEL, 2'd0);
    chk("rst.clr", VCLR, 1'b0);
    chk("rst.ena", VENABLE, 1'b0);
    chk("rst.busy", VBUSY, 1'b0);
    chk("rst.done", VDONE, 4'b0000);
    chk("rst.result", VRESULT, 4'b0000);
    VRESET_N = 1'b1;
    cyc(1);
    chk("post_rst.idle", VBUSY, 1'b0);

    // Single channel, comparator stuck high.
    conv(4'b0001, 3'b111, 3'b111, 8, 2'd0, 4'b0001, "ch0_hi");

    // Fresh reset, then all channels requesting: 0,1,2,3,0 spaced 9 cycles.
    VRESET_N = 1'b0;
    cyc(1);
    chk("rst2.result", VRESULT, 4'b0000);
    VRESET_N = 1'b1;
    cyc(1);
    VREQ  = 4'b1111;
    VCOMP = 1'b0;
    t = 0; np = 0; last = 0;
    while (np < 5 && t < 60) begin
      cyc(1);
      t++;
      if (VDONE != 4'b0000) begin
        chk("rr.order", VDONE, rr_exp[np]);
        if (np == 0) chk("rr.first_latency", t, 8);
        else         chk("rr.spacing", t - last, 9);
        last = t;
        np++;
      end
    end
    chk("rr.pulses", np, 5);
    VREQ = 4'b0000;
    cyc(2);

    // Majority vote on channel 2.
    conv(4'b0100, 3'b000, 3'b101, 8, 2'd2, 4'b0100, "maj_101");
    conv(4'b0100, 3'b000, 3'b010, 8, 2'd2, 4'b0000, "maj_010");

    // Request withdrawn right after the grant still completes.
    conv(4'b0010, 3'b000, 3'b111, 2, 2'd1, 4'b0010, "drop");

    // Comparator activity during SETTLE is ignored.
    conv(4'b1000, 3'b101, 3'b000, 8, 2'd3, 4'b0010, "settle_ign");

    // Leave pointer on channel 0 so a pointer not restored by reset would grant channel 3 next.
    conv(4'b0001, 3'b000, 3'b111, 8, 2'd0, 4'b0011, "ch0_again");

    // Reset in the middle of SAMPLE on channel 2.
    VREQ  = 4'b0100;
    VCOMP = 1'b1;
    cyc(6);
    chk("abort.in_sample", VENABLE, 1'b1);
    chk("abort.sel", VSEL, 2'd2);
    VRESET_N = 1'b0;
    #1;
    chk("abort.ena", VENABLE, 1'b0);
    chk("abort.busy", VBUSY, 1'b0);
    chk("abort.sel_rst", VSEL, 2'd0);
    chk("abort.result", VRESULT, 4'b0000);
    chk("abort.clr", VCLR, 1'b0);
    VREQ = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("abort.no_done", VDONE, 4'b0000);
    end
    VRESET_N = 1'b1;
    conv(4'b1001, 3'b000, 3'b111, 8, 2'd0, 4'b0001, "post_abort0");
    conv(4'b1001, 3'b000, 3'b000, 8, 2'd3, 4'b0001, "post_abort3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
